fir_mac_sequencer: RTL and testbench
====================================

FIR_MAC_SEQUENCER -- requirements
Module: fir_mac_sequencer

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 24: sample width, passed through to the package and not used internally except for documentation.
REQ-002 The block SHALL have parameter FIR_DEPTH, default 256: number of taps and delay-line entries; must be a power of 2.
REQ-003 The block SHALL have parameter NUM_PIPELINES, default 8: parallel MAC lanes; must divide FIR_DEPTH.
REQ-004 The block SHALL have parameter MAC_LATENCY, default 3: cycles from a group issue to its accumulation.
REQ-005 The block SHALL have a single clock i_clk, and reset i_rst SHALL be synchronous and active-high.
REQ-006 The block SHALL have ports i_clk (in, 1, clock) and i_rst (in, 1, synchronous active-high reset).
REQ-007 The block SHALL have port i_en (in, 1): global advance enable.
REQ-008 The block SHALL have ports i_sample_valid (in, 1) and o_sample_ready (out, 1): new deserialized sample handshake.
REQ-009 The block SHALL have ports o_wr_en (out, 1) and o_wr_addr (out, ADDR_W=log2(FIR_DEPTH)): delay-line RAM write.
REQ-010 The block SHALL have ports o_issue_valid (out, 1), o_samp_addr (out, ADDR_W) and o_coef_addr (out, GRP_W=log2(FIR_DEPTH/NUM_PIPELINES)): tap-group issue; lane p reads sample (o_samp_addr - p) mod FIR_DEPTH and coefficient o_coef_addr*NUM_PIPELINES + p.
REQ-011 The block SHALL have port o_acc_clear (out, 1): qualifies the first group of a sample.
REQ-012 The block SHALL have ports o_result_valid (out, 1) and i_result_ready (in, 1): accumulator result handoff to the serializer.
REQ-013 The block SHALL have ports o_busy (out, 1; high when state is not IDLE) and o_primed (out, 1; high once FIR_DEPTH samples have been written).

Function
REQ-014 The FSM SHALL have the states IDLE, ISSUE, DRAIN and OUTPUT; G = FIR_DEPTH/NUM_PIPELINES (32 at defaults).
REQ-015 In IDLE, o_sample_ready SHALL equal i_en; when i_sample_valid && o_sample_ready at edge T, that cycle SHALL assert o_wr_en with o_wr_addr=head, latch newest=head, increment head mod FIR_DEPTH, and go to ISSUE.
REQ-016 ISSUE SHALL last G enabled cycles, with group g=0..G-1 producing o_issue_valid=1, o_coef_addr=g, o_samp_addr=(newest - g*NUM_PIPELINES) mod FIR_DEPTH, and o_acc_clear=1 only for g=0.
REQ-017 After g=G-1, the FSM SHALL go to DRAIN for MAC_LATENCY enabled cycles, with o_issue_valid=0.
REQ-018 The FSM SHALL then go to OUTPUT, holding o_result_valid=1 until i_result_ready; on valid&&ready it SHALL return to IDLE.
REQ-019 Latency SHALL be: accept at T, first issue at T+1, o_result_valid at T+G+MAC_LATENCY+1 (T+36 at defaults) when i_en is held high and i_result_ready is high.
REQ-020 While i_en=0, the state, g, drain counter and head SHALL hold; o_issue_valid, o_wr_en and o_sample_ready SHALL be 0; o_result_valid SHALL hold its value.
REQ-021 In states other than IDLE, o_sample_ready SHALL be 0 and samples SHALL NOT be accepted.
REQ-022 When a result handshake and i_sample_valid occur in the same cycle, the block SHALL accept the result only; the sample SHALL be accepted on the next IDLE cycle, with no bypass.
REQ-023 Address arithmetic SHALL be unsigned modulo FIR_DEPTH (head 255 -> 0; o_samp_addr for newest=3, g=1 -> 251).
REQ-024 The written-sample counter SHALL saturate at FIR_DEPTH, and o_primed SHALL rise in the cycle after the FIR_DEPTH-th write; results SHALL be produced regardless of o_primed.

Reset
REQ-025 When i_rst=1, the block SHALL enter IDLE with head=0, newest=0, g=0, drain counter=0, sample count=0.
REQ-026 When i_rst=1, all outputs SHALL be 0, except that o_sample_ready SHALL be 0 during reset and SHALL follow i_en after reset.
REQ-027 Reset in any state, including mid-ISSUE or OUTPUT, SHALL abandon the operation without emitting o_result_valid.

Structure
REQ-028 Package fir_pkg SHALL hold DATA_WIDTH, FIR_DEPTH, NUM_PIPELINES, MAC_LATENCY, derived ADDR_W, G and GRP_W, and the state enum typedef.
REQ-029 A single sub-module, fir_circ_ptr, SHALL implement the head pointer with wrap and the saturating sample counter that drives o_primed.
REQ-030 All outputs SHALL be registered or decoded from registered state only.

Verification
REQ-031 The bench SHALL cover: one sample after reset with i_en=1 and i_result_ready=1 -> o_wr_addr=0, 32 issue cycles with o_coef_addr 0..31 and o_samp_addr 0,248,240,...,8, o_acc_clear only on the first, o_result_valid 36 cycles after accept.
REQ-032 The bench SHALL cover: 257 samples -> the 257th writes address 0 (wrap), and o_primed goes high after the 256th write.
REQ-033 The bench SHALL cover: i_en=0 for 5 cycles mid-ISSUE at g=10 -> no issue pulses, g resumes at 10, and the result is delayed by exactly 5 cycles.
REQ-034 The bench SHALL cover: i_result_ready=0 for 20 cycles -> o_result_valid held and o_sample_ready=0 throughout; a sample presented at the same edge as the result handshake is accepted one cycle later.
REQ-035 The bench SHALL cover: i_rst asserted at g=20 -> next cycle IDLE, all outputs 0, head=0, no o_result_valid.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared configuration for the FIR MAC sequencer: default sizing, derived widths
// and the sequencer state encoding.
package fir_pkg;

    localparam int DATA_WIDTH    = 24;
    localparam int FIR_DEPTH     = 256;
    localparam int NUM_PIPELINES = 8;
    localparam int MAC_LATENCY   = 3;

    localparam int ADDR_W = $clog2(FIR_DEPTH);
    localparam int G      = FIR_DEPTH / NUM_PIPELINES;
    localparam int GRP_W  = (G > 1) ? $clog2(G) : 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_OUTPUT = 2'd3
    } fir_state_e;

    function automatic bit is_pow2(input int value);
        return (value > 0) && ((value & (value - 1)) == 0);
    endfunction

endpackage

// File: rtl/fir_circ_ptr.sv
// Delay-line write pointer with modulo wrap, plus a saturating fill counter
// that reports when every delay-line entry has been written at least once.
module fir_circ_ptr
#(
    parameter int FIR_DEPTH = 256,
    localparam int ADDR_W = $clog2(FIR_DEPTH)
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              advance,
    output logic [ADDR_W-1:0] head,
    output logic              primed
);
    import fir_pkg::*;

    localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W + 1)'(FIR_DEPTH);

    logic [ADDR_W-1:0] head_r;
    logic [ADDR_W:0]   count_r;

    // Head wraps naturally because FIR_DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_r  <= '0;
            count_r <= '0;
        end else if (advance) begin
            head_r <= head_r + ADDR_W'(1);
            if (count_r != FULL_COUNT) begin
                count_r <= count_r + (ADDR_W + 1)'(1);
            end
        end
    end

    assign head   = head_r;
    assign primed = (count_r == FULL_COUNT);

endmodule

// File: rtl/fir_mac_sequencer.sv
// Sequences one FIR evaluation per accepted sample: writes the delay line, issues
// tap groups to NUM_PIPELINES MAC lanes, waits for the MAC pipe, then hands off.
module fir_mac_sequencer
#(
    parameter int DATA_WIDTH    = fir_pkg::DATA_WIDTH,
    parameter int FIR_DEPTH     = fir_pkg::FIR_DEPTH,
    parameter int NUM_PIPELINES = fir_pkg::NUM_PIPELINES,
    parameter int MAC_LATENCY   = fir_pkg::MAC_LATENCY,
    localparam int ADDR_W = $clog2(FIR_DEPTH),
    localparam int GRP_W  = (FIR_DEPTH / NUM_PIPELINES > 1) ? $clog2(FIR_DEPTH / NUM_PIPELINES) : 1
)
(
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_en,
    input  logic              i_sample_valid,
    output logic              o_sample_ready,
    output logic              o_wr_en,
    output logic [ADDR_W-1:0] o_wr_addr,
    output logic              o_issue_valid,
    output logic [ADDR_W-1:0] o_samp_addr,
    output logic [GRP_W-1:0]  o_coef_addr,
    output logic              o_acc_clear,
    output logic              o_result_valid,
    input  logic              i_result_ready,
    output logic              o_busy,
    output logic              o_primed
);
    import fir_pkg::*;

    localparam int NUM_GRP = FIR_DEPTH / NUM_PIPELINES;
    localparam int DRN_W   = (MAC_LATENCY > 1) ? $clog2(MAC_LATENCY) : 1;

    localparam logic [GRP_W-1:0]  LAST_GRP   = GRP_W'(NUM_GRP - 1);
    localparam logic [DRN_W-1:0]  LAST_DRAIN = DRN_W'(MAC_LATENCY - 1);
    localparam logic [ADDR_W-1:0] LANE_STEP  = ADDR_W'(NUM_PIPELINES);

    if (!is_pow2(FIR_DEPTH) || FIR_DEPTH < 2) begin : g_bad_depth
        $error("FIR_DEPTH must be a power of two and at least 2");
    end
    if (NUM_PIPELINES < 1 || (FIR_DEPTH % NUM_PIPELINES) != 0) begin : g_bad_lanes
        $error("NUM_PIPELINES must divide FIR_DEPTH");
    end
    if (MAC_LATENCY < 1) begin : g_bad_latency
        $error("MAC_LATENCY must be at least 1");
    end
    if (DATA_WIDTH < 1) begin : g_bad_width
        $error("DATA_WIDTH must be at least 1");
    end

    fir_state_e        state_r;
    logic [GRP_W-1:0]  grp_r;
    logic [DRN_W-1:0]  drain_r;
    logic [ADDR_W-1:0] newest_r;
    logic              result_valid_r;

    logic [ADDR_W-1:0] head_s;
    logic              primed_s;
    logic              sample_ready_s;
    logic              accept_s;
    logic              issue_s;

    // Ready and issue are gated by i_en and i_rst so nothing is consumed while stalled or in reset.
    assign sample_ready_s = (state_r == ST_IDLE) && i_en && !i_rst;
    assign accept_s       = sample_ready_s && i_sample_valid;
    assign issue_s        = (state_r == ST_ISSUE) && i_en && !i_rst;

    fir_circ_ptr #(
        .FIR_DEPTH (FIR_DEPTH)
    ) u_circ_ptr (
        .clk     (i_clk),
        .rst     (i_rst),
        .advance (accept_s),
        .head    (head_s),
        .primed  (primed_s)
    );

    // Sequencer FSM; every register freezes while i_en is low.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r        <= ST_IDLE;
            grp_r          <= '0;
            drain_r        <= '0;
            newest_r       <= '0;
            result_valid_r <= 1'b0;
        end else if (i_en) begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        newest_r <= head_s;
                        grp_r    <= '0;
                        state_r  <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (grp_r == LAST_GRP) begin
                        grp_r   <= '0;
                        drain_r <= '0;
                        state_r <= ST_DRAIN;
                    end else begin
                        grp_r <= grp_r + GRP_W'(1);
                    end
                end
                ST_DRAIN: begin
                    if (drain_r == LAST_DRAIN) begin
                        drain_r        <= '0;
                        result_valid_r <= 1'b1;
                        state_r        <= ST_OUTPUT;
                    end else begin
                        drain_r <= drain_r + DRN_W'(1);
                    end
                end
                ST_OUTPUT: begin
                    if (i_result_ready) begin
                        result_valid_r <= 1'b0;
                        state_r        <= ST_IDLE;
                    end
                end
                default: begin
                    result_valid_r <= 1'b0;
                    state_r        <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_sample_ready = sample_ready_s;
    assign o_wr_en        = accept_s;
    assign o_wr_addr      = head_s;
    assign o_issue_valid  = issue_s;
    assign o_coef_addr    = grp_r;
    // Lane 0 of group g reads the sample g*NUM_PIPELINES positions older than the newest.
    assign o_samp_addr    = newest_r - (ADDR_W'(grp_r) * LANE_STEP);
    assign o_acc_clear    = issue_s && (grp_r == '0);
    assign o_result_valid = result_valid_r;
    assign o_busy         = (state_r != ST_IDLE);
    assign o_primed       = primed_s;

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Self-checking bench for fir_mac_sequencer: vector table, directed corner sequences
// and randomized traffic, all compared against a cycle-count reference model.
module tb_fir_mac_sequencer;

    localparam int D  = 256;
    localparam int NP = 8;
    localparam int G  = D / NP;
    localparam int L  = 3;

    logic       i_clk = 1'b0;
    logic       i_rst = 1'b1;
    logic       i_en = 1'b0;
    logic       i_sample_valid = 1'b0;
    logic       i_result_ready = 1'b0;
    logic       o_sample_ready;
    logic       o_wr_en;
    logic [7:0] o_wr_addr;
    logic       o_issue_valid;
    logic [7:0] o_samp_addr;
    logic [4:0] o_coef_addr;
    logic       o_acc_clear;
    logic       o_result_valid;
    logic       o_busy;
    logic       o_primed;

    always #5 i_clk = ~i_clk;

    fir_mac_sequencer dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_en           (i_en),
        .i_sample_valid (i_sample_valid),
        .o_sample_ready (o_sample_ready),
        .o_wr_en        (o_wr_en),
        .o_wr_addr      (o_wr_addr),
        .o_issue_valid  (o_issue_valid),
        .o_samp_addr    (o_samp_addr),
        .o_coef_addr    (o_coef_addr),
        .o_acc_clear    (o_acc_clear),
        .o_result_valid (o_result_valid),
        .i_result_ready (i_result_ready),
        .o_busy         (o_busy),
        .o_primed       (o_primed)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic cur_en, cur_sv, cur_rr, cur_rst;

    // Reference model: head/fill bookkeeping plus enabled cycles elapsed since accept.
    bit m_valid = 1'b0;
    int m_head, m_count, m_newest, m_elapsed;
    bit m_wait;

    int obs_ready, obs_wr, obs_wr_addr, obs_issue, obs_coef, obs_samp;
    int obs_clear, obs_rv, obs_busy, obs_primed;
    int n_issue, n_clear, n_rv, acc_cyc, rv_cyc, last_coef, samp31;
    bit rv_prev = 1'b0;

    typedef struct {
        logic rst, en, sv, rr;
        int   ready, wr, busy, issue, clear, rv, coef, samp;
    } vec_t;
    vec_t tbl[9];

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit m_idle();
        return (m_elapsed < 0) && !m_wait;
    endfunction

    task automatic model_reset();
        m_head = 0; m_count = 0; m_newest = 0; m_elapsed = -1; m_wait = 1'b0;
    endtask

    task automatic half_a(input logic en, input logic sv, input logic rr, input logic rst);
        bit e_ready, e_issue;
        i_en = en; i_sample_valid = sv; i_result_ready = rr; i_rst = rst;
        cur_en = en; cur_sv = sv; cur_rr = rr; cur_rst = rst;
        @(negedge i_clk);
        obs_ready = o_sample_ready; obs_wr = o_wr_en; obs_wr_addr = o_wr_addr;
        obs_issue = o_issue_valid; obs_coef = o_coef_addr; obs_samp = o_samp_addr;
        obs_clear = o_acc_clear; obs_rv = o_result_valid; obs_busy = o_busy; obs_primed = o_primed;
        if (o_issue_valid) begin
            n_issue++;
            last_coef = o_coef_addr;
            if (o_coef_addr == 5'd31) samp31 = o_samp_addr;
        end
        if (o_acc_clear) n_clear++;
        if (o_wr_en) acc_cyc = cyc;
        if (o_result_valid) begin
            n_rv++;
            if (!rv_prev) rv_cyc = cyc;
        end
        rv_prev = o_result_valid;
        if (m_valid) begin
            e_ready = !rst && en && m_idle();
            e_issue = !rst && en && (m_elapsed >= 0) && (m_elapsed < G);
            chk("ready", obs_ready, int'(e_ready));
            chk("wr_en", obs_wr, int'(e_ready && sv));
            if (e_ready && sv) chk("wr_addr", obs_wr_addr, m_head);
            chk("issue_valid", obs_issue, int'(e_issue));
            chk("acc_clear", obs_clear, int'(e_issue && m_elapsed == 0));
            if (e_issue) begin
                chk("coef_addr", obs_coef, m_elapsed);
                chk("samp_addr", obs_samp, ((m_newest - m_elapsed * NP) % D + D) % D);
            end
            chk("result_valid", obs_rv, int'(m_wait));
            chk("busy", obs_busy, int'(!m_idle()));
            chk("primed", obs_primed, int'(m_count >= D));
        end
    endtask

    task automatic half_b();
        @(posedge i_clk);
        cyc++;
        if (cur_rst) begin
            model_reset();
        end else if (cur_en) begin
            if (m_idle()) begin
                if (cur_sv) begin
                    m_newest  = m_head;
                    m_head    = (m_head + 1) % D;
                    m_count   = (m_count < D) ? m_count + 1 : D;
                    m_elapsed = 0;
                end
            end else if (m_elapsed >= 0) begin
                m_elapsed++;
                if (m_elapsed == G + L) begin
                    m_elapsed = -1;
                    m_wait    = 1'b1;
                end
            end else if (m_wait && cur_rr) begin
                m_wait = 1'b0;
            end
        end
        #1;
    endtask

    task automatic cycle(input logic en, input logic sv, input logic rr, input logic rst);
        half_a(en, sv, rr, rst);
        half_b();
    endtask

    task automatic run_until_idle(input int bound);
        for (int k = 0; k < bound && !m_idle(); k++) cycle(1'b1, 1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        int saved, hold_ok;

        tbl[0] = '{1'b1, 1'b1, 1'b1, 1'b1, 0, 0, 0, 0, 0, 0, 0, 0};
        tbl[1] = '{1'b0, 1'b0, 1'b1, 1'b1, 0, 0, 0, 0, 0, 0, 0, 0};
        tbl[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 1, 0, 0, 0, 0, 0, 0, 0};
        tbl[3] = '{1'b0, 1'b1, 1'b1, 1'b1, 1, 1, 0, 0, 0, 0, 0, 0};
        tbl[4] = '{1'b0, 1'b1, 1'b1, 1'b1, 0, 0, 1, 1, 1, 0, 0, 0};
        tbl[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 1, 0, 0, 0, 1, 248};
        tbl[6] = '{1'b0, 1'b1, 1'b0, 1'b1, 0, 0, 1, 1, 0, 0, 1, 248};
        tbl[7] = '{1'b1, 1'b1, 1'b0, 1'b1, 0, 0, 1, 0, 0, 0, 2, 240};
        tbl[8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1, 0, 0, 0, 0, 0, 0, 0};

        // Initial reset before the model takes over.
        i_rst = 1'b1;
        repeat (2) @(posedge i_clk);
        #1;
        model_reset();
        m_valid = 1'b1;

        for (int v = 0; v < 9; v++) begin
            half_a(tbl[v].en, tbl[v].sv, tbl[v].rr, tbl[v].rst);
            chk($sformatf("tbl%0d_ready", v), obs_ready, tbl[v].ready);
            chk($sformatf("tbl%0d_wr", v), obs_wr, tbl[v].wr);
            chk($sformatf("tbl%0d_busy", v), obs_busy, tbl[v].busy);
            chk($sformatf("tbl%0d_issue", v), obs_issue, tbl[v].issue);
            chk($sformatf("tbl%0d_clear", v), obs_clear, tbl[v].clear);
            chk($sformatf("tbl%0d_rv", v), obs_rv, tbl[v].rv);
            chk($sformatf("tbl%0d_coef", v), obs_coef, tbl[v].coef);
            chk($sformatf("tbl%0d_samp", v), obs_samp, tbl[v].samp);
            half_b();
        end

        // One sample straight after reset: full issue sweep and 36-cycle latency.
        n_issue = 0; n_clear = 0; rv_cyc = -1; acc_cyc = -1; samp31 = -1;
        cycle(1'b1, 1'b1, 1'b1, 1'b0);
        chk("first_wr_addr", obs_wr_addr, 0);
        for (int k = 0; k < 100 && rv_cyc < 0; k++) cycle(1'b1, 1'b0, 1'b1, 1'b0);
        chk("issue_count", n_issue, 32);
        chk("clear_count", n_clear, 1);
        chk("samp_at_g31", samp31, 8);
        chk("latency", rv_cyc - acc_cyc, 36);
        run_until_idle(10);

        // Five-cycle enable stall at g=10.
        n_issue = 0; rv_cyc = -1; acc_cyc = -1;
        cycle(1'b1, 1'b1, 1'b1, 1'b0);
        repeat (10) cycle(1'b1, 1'b0, 1'b1, 1'b0);
        saved = n_issue;
        repeat (5) cycle(1'b0, 1'b0, 1'b1, 1'b0);
        chk("stall_no_issue", n_issue - saved, 0);
        cycle(1'b1, 1'b0, 1'b1, 1'b0);
        chk("resume_issue", obs_issue, 1);
        chk("resume_coef", obs_coef, 10);
        for (int k = 0; k < 100 && rv_cyc < 0; k++) cycle(1'b1, 1'b0, 1'b1, 1'b0);
        chk("stall_latency", rv_cyc - acc_cyc, 41);
        run_until_idle(10);

        // Result back-pressure, then a sample offered on the handshake edge.
        rv_cyc = -1;
        cycle(1'b1, 1'b1, 1'b1, 1'b0);
        for (int k = 0; k < 100 && rv_cyc < 0; k++) cycle(1'b1, 1'b0, 1'b0, 1'b0);
        hold_ok = 0;
        for (int k = 0; k < 20; k++) begin
            cycle(1'b1, 1'b0, 1'b0, 1'b0);
            if (obs_rv == 1 && obs_ready == 0) hold_ok++;
        end
        chk("rv_hold_cycles", hold_ok, 20);
        cycle(1'b1, 1'b1, 1'b1, 1'b0);
        chk("handshake_rv", obs_rv, 1);
        chk("handshake_no_accept", obs_wr, 0);
        cycle(1'b1, 1'b1, 1'b1, 1'b0);
        chk("accept_after_handshake", obs_wr, 1);
        run_until_idle(100);

        // Reset mid-ISSUE at g=20.
        cycle(1'b1, 1'b1, 1'b1, 1'b0);
        repeat (20) cycle(1'b1, 1'b0, 1'b1, 1'b0);
        chk("pre_rst_coef", last_coef, 19);
        cycle(1'b1, 1'b0, 1'b1, 1'b1);
        chk("rst_issue_gated", obs_issue, 0);
        chk("rst_ready", obs_ready, 0);
        n_rv = 0;
        cycle(1'b1, 1'b0, 1'b1, 1'b0);
        chk("post_rst_busy", obs_busy, 0);
        chk("post_rst_coef", obs_coef, 0);
        chk("post_rst_samp", obs_samp, 0);
        chk("post_rst_primed", obs_primed, 0);
        chk("post_rst_ready", obs_ready, 1);
        repeat (40) cycle(1'b1, 1'b0, 1'b1, 1'b0);
        chk("post_rst_no_rv", n_rv, 0);
        cycle(1'b1, 1'b1, 1'b1, 1'b0);
        chk("post_rst_wr_addr", obs_wr_addr, 0);
        run_until_idle(100);

        // 257 samples: wrap of the head and the primed flag.
        cycle(1'b1, 1'b0, 1'b1, 1'b1);
        for (int s = 0; s < 257; s++) begin
            cycle(1'b1, 1'b1, 1'b1, 1'b0);
            chk("fill_accept", obs_wr, 1);
            if (s == 255) begin
                chk("primed_before_256", obs_primed, 0);
                cycle(1'b1, 1'b0, 1'b1, 1'b0);
                chk("primed_after_256", obs_primed, 1);
            end
            if (s == 256) chk("wrap_wr_addr", obs_wr_addr, 0);
            run_until_idle(100);
        end

        // Randomized traffic with occasional resets.
        for (int k = 0; k < 3000; k++) begin
            cycle(logic'($urandom_range(0, 9) != 0), logic'($urandom_range(0, 2) != 0),
                  logic'($urandom_range(0, 3) != 0), logic'($urandom_range(0, 499) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
